// File: rtl/fifo_word_serializer_pkg.sv
// Shared definitions for the FIFO read-side word serializer.
// The FIFO and the serializer both take their word width from this package.
package fifo_word_serializer_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        SEND = 2'd3
    } state_t;

endpackage

// File: rtl/fifo_word_serializer_if.sv
// Serializer's two bundles: the FIFO pop side and the byte stream side.
// The master modport is the serializer; the slave is the FIFO plus the byte consumer.
interface fifo_word_serializer_if
    import fifo_word_serializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_data;
    logic             fifo_read;
    logic [7:0]       byte_out;
    logic             byte_valid;
    logic             byte_ready;

    modport master (
        input  fifo_empty, fifo_data, byte_ready,
        output fifo_read, byte_out, byte_valid
    );

    modport slave (
        output fifo_empty, fifo_data, byte_ready,
        input  fifo_read, byte_out, byte_valid
    );

endinterface

// File: rtl/fifo_word_serializer_byte_shift_reg.sv
// Word holding register that presents one byte at a time and tracks which byte is out.
// Shifting moves the next byte toward whichever end MSB_FIRST selects as the output.
module byte_shift_reg #(
    parameter int WIDTH     = 32,
    parameter int BYTES     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] data,
    output logic [7:0]       byte_out,
    output logic             last
);

    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [WIDTH-1:0] sreg;
    logic [IDX_W-1:0] index;

    // The caller never shifts on the last byte, so index stays within 0..BYTES-1.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sreg  <= '0;
            index <= '0;
        end else if (load) begin
            sreg  <= data;
            index <= '0;
        end else if (shift) begin
            sreg  <= MSB_FIRST ? (sreg << 8) : (sreg >> 8);
            index <= index + IDX_W'(1);
        end
    end

    assign byte_out = MSB_FIRST ? sreg[WIDTH-1 -: 8] : sreg[7:0];
    assign last     = (index == IDX_W'(BYTES - 1));

endmodule

// File: rtl/fifo_word_serializer.sv
// Pops 32-bit words from a synchronous FIFO and streams each one out as bytes.
// Also counts words whose final byte was accepted by the consumer.
module fifo_word_serializer
    import fifo_word_serializer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int BYTES     = DEFAULT_BYTES,
    parameter bit MSB_FIRST = 1'b0,
    parameter int CNT_W     = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable,
    fifo_word_serializer_if.master bus,
    output logic                  busy,
    output logic [CNT_W-1:0]      words_sent
);

    state_t     state;
    state_t     state_next;
    logic       handshake;
    logic       last_byte;
    logic       load;
    logic       shift;
    logic       can_pop;
    logic [7:0] shift_byte;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Enable only matters at word boundaries, so a word in flight always finishes.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (can_pop) state_next = REQ;
            REQ:  state_next = WAIT;
            WAIT: state_next = SEND;
            SEND: if (handshake && last_byte) state_next = can_pop ? REQ : IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign can_pop        = enable && !bus.fifo_empty;
    assign handshake      = (state == SEND) && bus.byte_ready;
    assign load           = (state == WAIT);
    assign shift          = handshake && !last_byte;
    assign bus.fifo_read  = (state == REQ);
    assign bus.byte_valid = (state == SEND);
    assign bus.byte_out   = shift_byte;
    assign busy           = (state != IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            words_sent <= '0;
        end else if (handshake && last_byte) begin
            words_sent <= words_sent + CNT_W'(1);
        end
    end

    byte_shift_reg #(
        .WIDTH     (WIDTH),
        .BYTES     (BYTES),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (load),
        .shift    (shift),
        .data     (bus.fifo_data),
        .byte_out (shift_byte),
        .last     (last_byte)
    );

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Bench for fifo_word_serializer: FIFO models feed two instances (LSB-first/16-bit count
// and MSB-first/2-bit count) while scoreboards compare every accepted byte.
module tb_fifo_word_serializer;
    import fifo_word_serializer_pkg::*;

    localparam int WIDTH = 32;
    localparam int BYTES = 4;
    localparam int CNT_W = 16;
    localparam int CNT_W1 = 2;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic enable = 1'b0;
    logic busy;
    logic [CNT_W-1:0] words_sent;

    logic reset_n1 = 1'b0;
    logic enable1 = 1'b0;
    logic busy1;
    logic [CNT_W1-1:0] words_sent1;

    int checks = 0;
    int passes = 0;
    int cycle = 0;

    fifo_word_serializer_if #(.WIDTH(WIDTH)) bus ();
    fifo_word_serializer_if #(.WIDTH(WIDTH)) bus1 ();

    fifo_word_serializer #(
        .WIDTH(WIDTH), .BYTES(BYTES), .MSB_FIRST(1'b0), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .bus(bus),
        .busy(busy), .words_sent(words_sent)
    );

    fifo_word_serializer #(
        .WIDTH(WIDTH), .BYTES(BYTES), .MSB_FIRST(1'b1), .CNT_W(CNT_W1)
    ) dut1 (
        .clock(clock), .reset_n(reset_n1), .enable(enable1), .bus(bus1),
        .busy(busy1), .words_sent(words_sent1)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cycle <= cycle + 1;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, actual, expected, cycle);
    endtask

    // FIFO models and expected-byte scoreboards: pointers written by one process each.
    logic [WIDTH-1:0] fifo_mem [0:255];
    logic [WIDTH-1:0] fifo_mem1 [0:255];
    int read_cyc [0:255];
    int unsigned wr_ptr = 0, rd_ptr = 0, wr_ptr1 = 0, rd_ptr1 = 0;
    logic [7:0] exp_mem [0:1023];
    logic [7:0] exp_mem1 [0:1023];
    int unsigned exp_wr = 0, exp_rd = 0, exp_wr1 = 0, exp_rd1 = 0;
    int words_done = 0;
    logic stall_held = 1'b0;
    logic [7:0] held_byte = 8'h00;

    assign bus.fifo_empty  = (wr_ptr == rd_ptr);
    assign bus1.fifo_empty = (wr_ptr1 == rd_ptr1);
    initial bus1.byte_ready = 1'b1;

    always @(posedge clock) begin
        if (bus.fifo_read) begin
            check_output("read_nonempty", 32'(wr_ptr != rd_ptr), 32'd1);
            bus.fifo_data <= fifo_mem[rd_ptr % 256];
            read_cyc[rd_ptr % 256] <= cycle;
            rd_ptr <= rd_ptr + 1;
        end
        if (bus1.fifo_read) begin
            check_output("read_nonempty1", 32'(wr_ptr1 != rd_ptr1), 32'd1);
            bus1.fifo_data <= fifo_mem1[rd_ptr1 % 256];
            rd_ptr1 <= rd_ptr1 + 1;
        end
    end

    always @(negedge clock) begin
        if (!reset_n) begin
            exp_rd = rd_ptr * BYTES;
            words_done = 0;
            stall_held = 1'b0;
            check_output("reset_byte_valid", 32'(bus.byte_valid), 32'd0);
            check_output("reset_fifo_read", 32'(bus.fifo_read), 32'd0);
            check_output("reset_byte_out", 32'(bus.byte_out), 32'd0);
            check_output("reset_busy", 32'(busy), 32'd0);
            check_output("reset_words_sent", 32'(words_sent), 32'd0);
        end else begin
            check_output("words_sent", 32'(words_sent), 32'(CNT_W'(words_done)));
            if (stall_held && bus.byte_valid) check_output("stall_hold", 32'(bus.byte_out), 32'(held_byte));
            if (bus.byte_valid && bus.byte_ready) begin
                if (exp_rd < exp_wr) check_output("byte", 32'(bus.byte_out), 32'(exp_mem[exp_rd % 1024]));
                else check_output("unexpected_byte", 32'd1, 32'd0);
                exp_rd++;
                if (exp_rd % BYTES == 0) words_done++;
            end
            stall_held = bus.byte_valid && !bus.byte_ready;
            held_byte = bus.byte_out;
        end
        if (reset_n1 && bus1.byte_valid && bus1.byte_ready) begin
            if (exp_rd1 < exp_wr1) check_output("byte_msb", 32'(bus1.byte_out), 32'(exp_mem1[exp_rd1 % 1024]));
            else check_output("unexpected_byte_msb", 32'd1, 32'd0);
            exp_rd1++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Expected bytes are just the word's bytes taken in the configured order.
    task automatic apply_stimulus(input logic [WIDTH-1:0] word);
        fifo_mem[wr_ptr % 256] = word;
        for (int i = 0; i < BYTES; i++) begin
            exp_mem[exp_wr % 1024] = 8'((word >> (8 * i)) & 32'hFF);
            exp_wr++;
        end
        wr_ptr++;
    endtask

    task automatic apply_stimulus1(input logic [WIDTH-1:0] word);
        fifo_mem1[wr_ptr1 % 256] = word;
        for (int i = 0; i < BYTES; i++) begin
            exp_mem1[exp_wr1 % 1024] = 8'((word >> (8 * (BYTES - 1 - i))) & 32'hFF);
            exp_wr1++;
        end
        wr_ptr1++;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_rd != exp_wr || busy || wr_ptr != rd_ptr) && n < 600) begin
            tick(1);
            n++;
        end
        check_output(name, 32'(n < 600), 32'd1);
    endtask

    task automatic wait_bytes(input string name, input int unsigned target);
        int n = 0;
        while (exp_rd < target && n < 200) begin
            tick(1);
            n++;
        end
        check_output(name, 32'(n < 200), 32'd1);
    endtask

    initial begin
        int unsigned base;
        int ws_before;
        int pushed;
        logic [3:0] pat;
        bus.byte_ready = 1'b0;

        // Reset values, then single word with latency checks.
        tick(3);
        check_output("idle_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        reset_n1 = 1'b1;
        enable = 1'b1;
        bus.byte_ready = 1'b1;
        tick(2);
        apply_stimulus(32'hDDCCBBAA);
        tick(1);
        check_output("lat_fifo_read", 32'(bus.fifo_read), 32'd1);
        tick(1);
        check_output("lat_wait_read", 32'(bus.fifo_read), 32'd0);
        check_output("lat_wait_valid", 32'(bus.byte_valid), 32'd0);
        tick(1);
        check_output("lat_first_valid", 32'(bus.byte_valid), 32'd1);
        check_output("first_byte", 32'(bus.byte_out), 32'hAA);
        wait_drain("drain_single");
        check_output("single_words", 32'(words_sent), 32'd1);
        check_output("single_reads", rd_ptr, 32'd1);
        check_output("single_idle", 32'(busy), 32'd0);

        // Backpressure with ready pattern 1,0,0,1.
        pat = 4'b1001;
        apply_stimulus(32'h44332211);
        for (int i = 0; i < 24; i++) begin
            bus.byte_ready = pat[i % 4];
            tick(1);
        end
        bus.byte_ready = 1'b1;
        wait_drain("drain_backpressure");
        check_output("bp_reads", rd_ptr, 32'd2);

        // Streaming three preloaded words.
        enable = 1'b0;
        base = rd_ptr;
        ws_before = int'(words_sent);
        for (int i = 0; i < 3; i++) apply_stimulus($urandom());
        tick(1);
        enable = 1'b1;
        wait_drain("drain_stream");
        for (int k = 1; k < 3; k++)
            check_output("stream_spacing", 32'(read_cyc[(base + k) % 256] - read_cyc[(base + k - 1) % 256]), 32'd6);
        check_output("stream_words", 32'(words_sent), 32'(ws_before + 3));
        tick(10);
        check_output("stream_no_extra_read", rd_ptr, base + 3);

        // Enable dropped after the second byte of word 1.
        enable = 1'b0;
        base = rd_ptr;
        apply_stimulus($urandom());
        apply_stimulus($urandom());
        tick(1);
        enable = 1'b1;
        wait_bytes("wait_en_drop", exp_rd + 2);
        enable = 1'b0;
        tick(20);
        check_output("en_drop_reads", rd_ptr, base + 1);
        check_output("en_drop_idle", 32'(busy), 32'd0);
        check_output("en_drop_word_done", exp_rd, (base + 1) * BYTES);
        enable = 1'b1;
        wait_drain("drain_en_return");
        check_output("en_return_reads", rd_ptr, base + 2);

        // Randomized traffic with random backpressure.
        pushed = 0;
        for (int c = 0; c < 400; c++) begin
            bus.byte_ready = ($urandom_range(0, 2) != 0);
            if (pushed < 20 && (wr_ptr - rd_ptr) < 3 && $urandom_range(0, 3) == 0) begin
                apply_stimulus($urandom());
                pushed++;
            end
            tick(1);
        end
        bus.byte_ready = 1'b1;
        wait_drain("drain_random");

        // Reset during the third byte discards the word.
        apply_stimulus(32'h87654321);
        wait_bytes("wait_reset_point", exp_rd + 2);
        check_output("pre_reset_byte", 32'(bus.byte_out), 32'h65);
        reset_n = 1'b0;
        #1;
        check_output("async_reset_valid", 32'(bus.byte_valid), 32'd0);
        check_output("async_reset_words", 32'(words_sent), 32'd0);
        tick(2);
        reset_n = 1'b1;
        tick(1);
        apply_stimulus(32'h0A0B0C0D);
        wait_drain("drain_after_reset");
        check_output("post_reset_words", 32'(words_sent), 32'd1);

        // MSB-first order and 2-bit counter wrap on the second instance.
        enable1 = 1'b1;
        apply_stimulus1(32'hDDCCBBAA);
        for (int i = 0; i < 4; i++) apply_stimulus1($urandom());
        begin
            int n = 0;
            while ((exp_rd1 != exp_wr1 || busy1) && n < 200) begin
                tick(1);
                n++;
            end
            check_output("drain_msb", 32'(n < 200), 32'd1);
        end
        check_output("msb_bytes", exp_rd1, 32'd20);
        check_output("wrap_words_sent", 32'(words_sent1), 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
